// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory access / writeback / next-PC stage of the sequenced
// 64-bit RISC-V core. IDLE captures the execute-stage results on start, MEM
// runs the dmem req/ready handshake with a timeout, WB retires in one cycle.
module mem_wb_stage #(
  parameter int XLEN        = 64,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [6:0]      opcode,
  input  logic [2:0]      func3,
  input  logic [4:0]      rd,
  input  logic [XLEN-1:0] alu_out,
  input  logic [2:0]      branch_sel,
  input  logic [XLEN-1:0] jal_output,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  output logic            busy,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ready,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic [XLEN-1:0] pc_next,
  output logic            pc_valid,
  output logic            done,
  output logic            mem_err
);
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_SD   = 7'b0100011;
  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_REG  = 7'b0110011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, MEM, WB} state_t;
  state_t state, state_nx;

  logic [6:0]      c_op;
  logic [2:0]      c_f3, c_bsel;
  logic [4:0]      c_rd;
  logic [XLEN-1:0] c_alu, c_jal, c_sd, c_pc, c_imm;
  logic [7:0]      cnt;
  logic            wen_q;

  // In IDLE the WB values are computed straight from the ports (capture and
  // WB entry happen on the same edge); in MEM they come from the captured copy.
  logic            sel;
  logic [6:0]      s_op;
  logic [2:0]      s_f3, s_bsel;
  logic [4:0]      s_rd;
  logic [XLEN-1:0] s_alu, s_jal, s_pc, s_imm, pc_inc, pc_imm;
  logic            s_mem, timeout_hit;
  logic            wb_we;
  logic [XLEN-1:0] wb_data, wb_pc;

  assign sel    = (state == IDLE);
  assign s_op   = sel ? opcode     : c_op;
  assign s_f3   = sel ? func3      : c_f3;
  assign s_bsel = sel ? branch_sel : c_bsel;
  assign s_rd   = sel ? rd         : c_rd;
  assign s_alu  = sel ? alu_out    : c_alu;
  assign s_jal  = sel ? jal_output : c_jal;
  assign s_pc   = sel ? pc         : c_pc;
  assign s_imm  = sel ? imm        : c_imm;
  assign pc_inc = s_pc + 1'b1;
  assign pc_imm = s_pc + s_imm;
  assign s_mem  = (s_op == OP_LD || s_op == OP_SD) && s_f3 == 3'b011;
  // Final unanswered cycle: the request has been up MEM_TIMEOUT cycles.
  assign timeout_hit = (state == MEM) && !dmem_ready && (cnt == TO_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = s_mem ? MEM : WB;
      MEM:     if (dmem_ready || timeout_hit) state_nx = WB;
      WB:      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Writeback values by instruction class; unknown classes retire as no-ops
  always_comb begin
    wb_we   = 1'b0;
    wb_data = rf_wdata;
    wb_pc   = pc_inc;
    case (s_op)
      OP_IMM, OP_REG: begin wb_we = 1'b1; wb_data = s_alu; end
      OP_LD: if (s_f3 == 3'b011 && !timeout_hit) begin
        wb_we = 1'b1; wb_data = dmem_rdata;
      end
      OP_BR:  wb_pc = (s_bsel != 3'b111) ? pc_imm : pc_inc;
      OP_JAL: begin wb_we = 1'b1; wb_data = s_jal; wb_pc = pc_imm; end
      OP_JALR: if (s_f3 == 3'b000) begin
        wb_we = 1'b1; wb_data = pc_inc; wb_pc = s_alu;
      end
      default: ;
    endcase
    if (s_rd == 5'd0) wb_we = 1'b0;
  end

  // Operand capture, timeout counter, sticky error and held WB outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_op <= '0; c_f3 <= '0; c_bsel <= '0; c_rd <= '0;
      c_alu <= '0; c_jal <= '0; c_sd <= '0; c_pc <= '0; c_imm <= '0;
      cnt <= '0; mem_err <= 1'b0; wen_q <= 1'b0;
      rf_waddr <= '0; rf_wdata <= '0; pc_next <= '0;
    end else begin
      if (state == IDLE && start) begin
        c_op <= opcode; c_f3 <= func3; c_bsel <= branch_sel; c_rd <= rd;
        c_alu <= alu_out; c_jal <= jal_output; c_sd <= store_data;
        c_pc <= pc; c_imm <= imm;
      end
      if (state == MEM && !dmem_ready) cnt <= cnt + 8'd1;
      else                             cnt <= '0;
      if (timeout_hit) mem_err <= 1'b1;
      if (state_nx == WB) begin
        wen_q    <= wb_we;
        rf_waddr <= s_rd;
        rf_wdata <= wb_data;
        pc_next  <= wb_pc;
      end
    end
  end

  // Outputs decoded from state and captured request fields
  always_comb begin
    busy       = (state != IDLE);
    dmem_req   = (state == MEM);
    dmem_we    = (state == MEM) && (c_op == OP_SD);
    dmem_addr  = c_alu;
    dmem_wdata = c_sd;
    rf_we      = (state == WB) && wen_q;
    pc_valid   = (state == WB);
    done       = (state == WB);
  end
endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
Downstream neighbour of the execute/ALU stage in the counter-sequenced 64-bit RISC-V core. Captures the ALU result, branch select and JAL link value when the execute phase completes. Performs the data-memory access for ld/sd over a req/ready handshake, writes the register file, and produces the next PC for the fetch stage. Runs as a small FSM with a memory-wait timeout.

Parameters:
XLEN, 64, datapath and address width
MEM_TIMEOUT, 16, max cycles dmem_req may stay unanswered before abort (range 1..255)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle strobe: execute phase done, operands valid this cycle
opcode  input  7  instruction opcode
func3  input  3  instruction func3
rd  input  5  destination register index
alu_out  input  XLEN  ALU result / effective address / jalr target
branch_sel  input  3  ALU branch code; 3'b111 = not taken, any other value = taken
jal_output  input  XLEN  link value (pc+1) from ALU
store_data  input  XLEN  rs2 value for sd
pc  input  XLEN  PC of current instruction
imm  input  XLEN  sign-extended branch/jal offset, in instruction units
busy  output  1  FSM not in IDLE
dmem_req  output  1  memory request valid
dmem_we  output  1  1 = store, 0 = load
dmem_addr  output  XLEN  memory address
dmem_wdata  output  XLEN  store data
dmem_ready  input  1  memory accepts/completes request this cycle
dmem_rdata  input  XLEN  load data, valid when dmem_ready=1 and dmem_we=0
rf_we  output  1  register write strobe (one cycle)
rf_waddr  output  5  register write index
rf_wdata  output  XLEN  register write data
pc_next  output  XLEN  next PC
pc_valid  output  1  one-cycle strobe: pc_next valid
done  output  1  one-cycle strobe: instruction retired
mem_err  output  1  sticky: memory timeout occurred; cleared only by reset

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs 0, including pc_next, dmem_addr, rf_wdata and mem_err. Timeout counter=0. Any in-flight request is dropped immediately, with no wait for the clock.
- States: IDLE, MEM, WB.
- IDLE: start=1 registers all inputs. Class decode:
  - load (0000011/f3 011) or store (0100011/f3 011) -> MEM.
  - Everything else -> WB.
  - Unrecognised opcode -> WB as a no-op: rf_we=0, pc_next=pc+1.
- MEM:
  - dmem_req=1; dmem_addr=captured alu_out; dmem_we=1 for sd; dmem_wdata=captured store_data.
  - Request fields hold stable until dmem_ready is sampled 1.
  - On ready: load data captured -> WB.
  - Counter increments each MEM cycle without ready. Reaching MEM_TIMEOUT: mem_err<=1, req dropped -> WB with rf_we suppressed, pc_next=pc+1.
- WB: exactly one cycle. pc_valid=1 and done=1. rf_we=1 only for writing classes with rd!=0. Writes by class:
  - I-type 0010011 / R-type 0110011: rf_wdata=alu_out; pc_next=pc+1.
  - ld: rf_wdata=dmem_rdata; pc_next=pc+1.
  - sd: no write; pc_next=pc+1.
  - branch 1100011: no write; pc_next = pc+imm if branch_sel!=3'b111, else pc+1.
  - jal 1101111: rf_wdata=jal_output; pc_next=pc+imm.
  - jalr 1100111/f3 000: rf_wdata=pc+1; pc_next=alu_out.
- After WB -> IDLE.
- Latency:
  - Non-memory: start at cycle N -> done at N+1.
  - Memory: req first high at N+1; done one cycle after the ready cycle.
- start while busy: ignored, no effect on captured data.
- rd=0: rf_we forced 0, but pc_valid/done still pulse.
- Arithmetic: all PC sums mod 2^XLEN, wrap silently.
- Outputs: rf_wdata/rf_waddr/pc_next hold last value outside WB. Strobes are 0 outside WB.
- busy=1 in MEM and WB.

Test Plan:
- add: opcode 0110011, rd=5, alu_out=0x2A, pc=10, start -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x2A, pc_next=11, done=1.
- ld with ready after 3 cycles: alu_out=0x100, dmem_rdata=0xDEADBEEF, rd=7 -> dmem_req high 3 cycles with addr 0x100, we=0. Cycle after ready: rf_wdata=0xDEADBEEF, pc_next=pc+1.
- beq taken/not taken: pc=20, imm=-4, branch_sel=000 -> pc_next=16, rf_we=0. Same with branch_sel=111 -> pc_next=21.
- jal / jalr: pc=8, imm=5, jal_output=9, rd=1 -> rf_wdata=9, pc_next=13. jalr with alu_out=0x40 -> rf_wdata=9, pc_next=0x40.
- sd timeout: MEM_TIMEOUT=16, dmem_ready held 0 -> req drops after 16 cycles, mem_err=1 sticky, done pulses, pc_next=pc+1, no rf write.
- Reset mid-MEM and start while busy:
  - rst_n low during MEM -> dmem_req=0 immediately, state IDLE.
  - Second start during MEM -> ignored; first instruction's values are the ones retired.
